// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - button conditioning, direction arbitration and per-tick move issue
//
// Purpose:
//   Synchronises and debounces the four push-buttons, turns debounced rising
//   edges into direction requests, rejects reversals and no-op requests, and
//   offers one move per game tick to the snake engine over valid/ready.
// Ports:
//   clk, rst                         12 MHz clock, synchronous active-high reset
//   btn_up/right/down/left           raw active-high buttons (asynchronous)
//   move_valid, move_ready, move_dir move offer handshake; dir 00 up 01 right 10 down 11 left
//   cur_dir                          last direction accepted by the engine
//   tick_overrun                     sticky: a tick expired while a move was still unaccepted
module snake_move_ctrl #(
    parameter int DEB_CYCLES  = 600_000,
    parameter int TICK_CYCLES = 3_000_000,
    parameter int CNT_W       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [1:0] move_dir,
    output logic [1:0] cur_dir,
    output logic       tick_overrun
);

    typedef enum logic {ST_WAIT, ST_OFFER} state_t;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_CYCLES - 1);

    // Bit index equals the direction code: 0 up, 1 right, 2 down, 3 left.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] deb_cnt_q [4];
    logic [CNT_W-1:0] deb_cnt_d [4];
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    state_t           state_q, state_d;
    logic             move_valid_q, move_valid_d;
    logic [1:0]       move_dir_q, move_dir_d;
    logic [1:0]       cur_dir_q, cur_dir_d;
    logic             overrun_q, overrun_d;
    logic             pending_q, pending_d;
    logic [1:0]       pending_dir_q, pending_dir_d;

    logic       tick;
    logic [3:0] press;
    logic [1:0] press_dir;
    logic [1:0] ref_dir;
    logic       press_ok;

    // Input conditioning: the debounced level only moves after DEB_CYCLES
    // consecutive disagreeing samples; one agreeing sample restarts the count.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Fixed priority among simultaneous presses; losers are simply dropped.
    always_comb begin
        press_dir = 2'b00;
        if (press[0])      press_dir = 2'b00;
        else if (press[1]) press_dir = 2'b01;
        else if (press[2]) press_dir = 2'b10;
        else if (press[3]) press_dir = 2'b11;
    end

    // Compare against the direction the snake will have after this edge, so a
    // press on the handshake cycle is judged against the move being committed.
    assign ref_dir  = (move_valid_q && move_ready) ? move_dir_q : cur_dir_q;
    assign press_ok = (|press) && (press_dir != ref_dir) && (press_dir != (ref_dir ^ 2'b10));

    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        move_valid_d  = move_valid_q;
        move_dir_d    = move_dir_q;
        cur_dir_d     = cur_dir_q;
        overrun_d     = overrun_q;
        pending_d     = pending_q;
        pending_dir_d = pending_dir_q;
        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    state_d      = ST_OFFER;
                    move_valid_d = 1'b1;
                    move_dir_d   = pending_q ? pending_dir_q : cur_dir_q;
                    pending_d    = 1'b0;
                end
            end
            ST_OFFER: begin
                if (move_valid_q && move_ready) begin
                    state_d      = ST_WAIT;
                    move_valid_d = 1'b0;
                    cur_dir_d    = move_dir_q;
                end else if (tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
        // Applied after the tick logic: a press coinciding with a tick in WAIT
        // lands in pending for the following tick rather than this one.
        if (press_ok) begin
            pending_d     = 1'b1;
            pending_dir_d = press_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            tick_cnt_q    <= '0;
            state_q       <= ST_WAIT;
            move_valid_q  <= 1'b0;
            move_dir_q    <= 2'b01;
            cur_dir_q     <= 2'b01;
            overrun_q     <= 1'b0;
            pending_q     <= 1'b0;
            pending_dir_q <= 2'b00;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            move_valid_q  <= move_valid_d;
            move_dir_q    <= move_dir_d;
            cur_dir_q     <= cur_dir_d;
            overrun_q     <= overrun_d;
            pending_q     <= pending_d;
            pending_dir_q <= pending_dir_d;
        end
    end

    assign move_valid   = move_valid_q;
    assign move_dir     = move_dir_q;
    assign cur_dir      = cur_dir_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - self-checking bench for snake_move_ctrl
module tb_snake_move_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       move_valid, move_ready;
    logic [1:0] move_dir, cur_dir;
    logic       tick_overrun;

    snake_move_ctrl #(.DEB_CYCLES(DEB), .TICK_CYCLES(TICK), .CNT_W(23)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
        .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
        .cur_dir(cur_dir), .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    logic [3:0] btns;
    assign btns = {btn_left, btn_down, btn_right, btn_up};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!move_valid && k < 64);
        tests++;
        if (!move_valid) begin
            fails++;
            $display("FAIL %s: move_valid got 0 expected 1 within 64 cycles", name);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Behavioural model: sample history per button, window test for debounce,
    // modulo arithmetic for the tick, and a boolean offer flag.
    logic [15:0] m_hist [4];
    bit          m_lvl  [4];
    bit          m_rose [4];
    int          m_n;
    bit          m_valid, m_pend, m_ovr;
    bit   [1:0]  m_dir, m_cur, m_pdir;

    always @(posedge clk) begin
        bit       tick, hs, press, flip;
        bit [1:0] r, pd;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = '0;
                m_lvl[i]  = 1'b0;
                m_rose[i] = 1'b0;
            end
            m_n = 0; m_valid = 0; m_pend = 0; m_ovr = 0;
            m_dir = 2'b01; m_cur = 2'b01; m_pdir = 2'b00;
        end else begin
            tick = ((m_n % TICK) == TICK - 1);
            m_n++;
            press = 1'b0;
            pd    = 2'b00;
            for (int i = 3; i >= 0; i--) begin
                if (m_rose[i]) begin
                    press = 1'b1;
                    pd    = 2'(i);
                end
            end
            hs = m_valid && move_ready;
            r  = hs ? m_dir : m_cur;
            if (!m_valid) begin
                if (tick) begin
                    m_valid = 1'b1;
                    m_dir   = m_pend ? m_pdir : m_cur;
                    m_pend  = 1'b0;
                end
            end else if (hs) begin
                m_cur   = m_dir;
                m_valid = 1'b0;
            end else if (tick) begin
                m_ovr = 1'b1;
            end
            if (press && pd != r && pd != (r ^ 2'b10)) begin
                m_pend = 1'b1;
                m_pdir = pd;
            end
            // Bit 0 is the raw sample of this edge; the debouncer sees raw
            // samples two edges old, so the window is bits 2..DEB+1.
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = {m_hist[i][14:0], btns[i]};
                flip = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (m_hist[i][j] == m_lvl[i]) flip = 1'b0;
                m_rose[i] = flip && !m_lvl[i];
                if (flip) m_lvl[i] = !m_lvl[i];
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("model move_valid", move_valid, m_valid);
            check("model move_dir", move_dir, m_dir);
            check("model cur_dir", cur_dir, m_cur);
            check("model tick_overrun", tick_overrun, m_ovr);
        end
    end

    initial begin
        int t_prev, hs_cnt;
        int rem [4];
        bit lvl [4];

        rst = 1'b1; move_ready = 1'b1;
        btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
        step(2);
        chk_en = 1'b1;
        rst = 1'b0;

        // Reset state and idle ticking
        check("reset move_valid", move_valid, 0);
        check("reset move_dir", move_dir, 2'b01);
        check("reset cur_dir", cur_dir, 2'b01);
        check("reset tick_overrun", tick_overrun, 0);
        t_prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("idle tick");
            if (t_prev >= 0) check("tick period", cyc - t_prev, TICK);
            t_prev = cyc;
            check("idle move_dir", move_dir, 2'b01);
            step(1);
            check("idle pulse width", move_valid, 0);
            check("idle cur_dir", cur_dir, 2'b01);
        end

        // Glitch rejected, held up accepted
        btn_down = 1; step(3); btn_down = 0;
        btn_up = 1; step(10); btn_up = 0;
        wait_valid("up tick");
        check("up move_dir", move_dir, 2'b00);
        step(1);
        check("up cur_dir", cur_dir, 2'b00);

        // Reversal ignored; last accepted press wins
        do_reset();
        wait_valid("left tick a");
        step(1);
        btn_left = 1; step(5); btn_left = 0;
        wait_valid("left tick b");
        check("left rejected move_dir", move_dir, 2'b01);
        step(1);
        btn_down = 1; step(2);
        btn_up = 1; step(3);
        btn_down = 0; step(2);
        btn_up = 0;
        wait_valid("down-up tick");
        check("down then up move_dir", move_dir, 2'b00);
        step(1);
        check("down then up cur_dir", cur_dir, 2'b00);

        // Simultaneous presses: up beats down
        do_reset();
        wait_valid("prio tick a");
        step(1);
        btn_up = 1; btn_down = 1; step(5); btn_up = 0; btn_down = 0;
        wait_valid("prio tick b");
        check("priority move_dir", move_dir, 2'b00);

        // Backpressure: held offer, overrun, single handshake
        step(1);
        move_ready = 0;
        wait_valid("stall tick");
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("stall move_valid held", move_valid, 1);
            check("stall move_dir held", move_dir, 2'b00);
        end
        check("stall tick_overrun", tick_overrun, 1);
        move_ready = 1;
        hs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (move_valid && move_ready) hs_cnt++;
            step(1);
        end
        check("stall handshake count", hs_cnt, 1);

        // Reset during OFFER with a pending left press
        step(1);
        move_ready = 0;
        wait_valid("rst tick");
        btn_left = 1; step(5); btn_left = 0; step(4);
        do_reset();
        check("rst move_valid", move_valid, 0);
        check("rst cur_dir", cur_dir, 2'b01);
        check("rst tick_overrun", tick_overrun, 0);
        check("rst move_dir", move_dir, 2'b01);
        move_ready = 1;
        wait_valid("post rst tick");
        check("rst pending cleared", move_dir, 2'b01);

        // Randomized buttons, backpressure and occasional reset
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            lvl[i] = 1'b0;
        end
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ($urandom_range(0, 2) == 0);
                    rem[i] = $urandom_range(1, 12);
                end
                rem[i]--;
            end
            btn_up = lvl[0]; btn_right = lvl[1]; btn_down = lvl[2]; btn_left = lvl[3];
            move_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
